// File: rtl/add8_arbiter.sv
// add8_arbiter: round-robin sequencer sharing one 8-bit adder between NREQ
// requesters. Each requester has a valid/ready request handshake and a
// registered result slot. Operations are tracked through the adder's fixed
// latency by a tag shift register, so at most one operation per requester
// is ever outstanding.
//
// Build option: define ADD8_ARB_PRIO_EN for fixed priority (lowest eligible
// index wins, no round-robin pointer). Default is round-robin.
module add8_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [8*NREQ-1:0] rsp_sum,
    output logic [NREQ-1:0]   rsp_cout,
    output logic [7:0]        add_cina,
    output logic [7:0]        add_cinb,
    output logic              add_cin,
    input  logic [7:0]        add_sum,
    input  logic              add_cout,
    output logic              busy
);

    localparam int IW  = $clog2(NREQ);
    localparam int NST = LAT + 1;

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
    } tag_t;

    tag_t [NST-1:0]    tag_q, tag_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [8*NREQ-1:0] rsp_sum_q, rsp_sum_d;
    logic [NREQ-1:0]   rsp_cout_q, rsp_cout_d;
    logic [7:0]        opa_q, opa_d;
    logic [7:0]        opb_q, opb_d;
    logic              opc_q, opc_d;

    logic [NREQ-1:0]   inflight;
    logic [NREQ-1:0]   eligible;
    logic              gnt_found;
    logic [IW-1:0]     gnt_idx;

    // Requesters with a tag anywhere in the pipeline are blocked; so is any
    // requester whose result has not yet been consumed.
    always_comb begin
        inflight = '0;
        for (int unsigned s = 0; s < NST; s++) begin
            if (tag_q[s].vld) begin
                inflight[tag_q[s].idx] = 1'b1;
            end
        end
        eligible = req_valid & ~inflight & ~rsp_valid_q;
    end

`ifdef ADD8_ARB_PRIO_EN
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_found && eligible[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0] ptr_q, ptr_d;

    // Round-robin search starting at the index after the last grant.
    always_comb begin
        int unsigned cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
        ptr_d = ptr_q;
        if (gnt_found) begin
            ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Round-robin pointer register; requester 0 has first priority after reset.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Grant decode, operand issue and tag injection.
    always_comb begin
        int unsigned sel;
        sel       = 32'(gnt_idx);
        req_ready = '0;
        opa_d     = opa_q;
        opb_d     = opb_q;
        opc_d     = opc_q;
        if (gnt_found) begin
            req_ready[sel] = 1'b1;
            opa_d          = req_a[sel*8 +: 8];
            opb_d          = req_b[sel*8 +: 8];
            opc_d          = req_cin[sel];
        end
        tag_d[0].vld = gnt_found;
        tag_d[0].idx = gnt_idx;
        for (int unsigned s = 1; s < NST; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    // Result capture from the adder when a valid tag leaves the pipeline,
    // and release of consumed results.
    always_comb begin
        int unsigned ridx;
        ridx        = 32'(tag_q[NST-1].idx);
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        if (tag_q[NST-1].vld) begin
            rsp_valid_d[ridx]       = 1'b1;
            rsp_sum_d[ridx*8 +: 8]  = add_sum;
            rsp_cout_d[ridx]        = add_cout;
        end
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            opc_q       <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opc_q       <= opc_d;
        end
    end

    // Activity flag: anything in the pipeline or any result waiting.
    always_comb begin
        busy = |rsp_valid_q;
        for (int unsigned s = 0; s < NST; s++) begin
            busy = busy | tag_q[s].vld;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign add_cina  = opa_q;
    assign add_cinb  = opb_q;
    assign add_cin   = opc_q;

endmodule
